// File: rtl/cordic_result_collector_if.sv
// cordic_result_collector_if: request credit and result FIFO handshake bundle
interface cordic_result_collector_if #(parameter int DATA_W = 32);
  logic req_valid, req_ready, flush, res_valid, res_ready;
  logic [DATA_W-1:0] pipe_result, res_data;
  modport master(output req_valid, flush, pipe_result, res_ready, input req_ready, res_valid, res_data);
  modport slave(input req_valid, flush, pipe_result, res_ready, output req_ready, res_valid, res_data);
endinterface

// File: rtl/cordic_result_collector.sv
// cordic_result_collector: credit-gated capture of cordic pipeline results into an in-order FIFO
module cordic_result_collector #(
  parameter int LATENCY = 7,
  parameter int DEPTH = 16,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  cordic_result_collector_if.slave bus,
  output logic [$clog2(LATENCY+1)-1:0] inflight_cnt,
  output logic [$clog2(DEPTH+1)-1:0] fifo_cnt
);
  localparam int IW = $clog2(LATENCY+1);
  localparam int FW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = FW + 1;
  logic [LATENCY-1:0] vld;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic accept, push, pop;
  // every accepted request owns a FIFO slot, so the pipeline can never overrun the FIFO
  assign bus.req_ready = ~bus.flush & ((SW'(inflight_cnt) + SW'(fifo_cnt)) < SW'(DEPTH));
  assign accept = bus.req_valid & bus.req_ready & ~bus.flush;
  assign push = vld[LATENCY-1] & ~bus.flush;
  assign pop = bus.res_valid & bus.res_ready & ~bus.flush;
  assign bus.res_valid = fifo_cnt != '0;
  assign bus.res_data = bus.res_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      inflight_cnt <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      vld <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      inflight_cnt <= '0;
      fifo_cnt <= '0;
    end else begin
      vld <= LATENCY'({vld, accept});
      inflight_cnt <= inflight_cnt + IW'(accept) - IW'(push);
      fifo_cnt <= fifo_cnt + FW'(push) - FW'(pop);
      if (push) mem[wr_ptr] <= bus.pipe_result;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  assert property (@(posedge clk) disable iff (!rst_n) push |-> fifo_cnt != FW'(DEPTH));
endmodule

// File: tb/tb_cordic_result_collector.sv
// tb_cordic_result_collector: scoreboard bench with a cycle-accurate reference of the credit/FIFO behaviour
module tb_cordic_result_collector;
  localparam int L = 7;
  localparam int D = 16;
  logic clk = 0, rst_n = 0;
  logic [2:0] inflight_cnt;
  logic [4:0] fifo_cnt;
  logic [31:0] cyc = 0, ofs = 0;
  int checks = 0, failures = 0, acc_dut = 0, stalls = 0;
  typedef struct {logic [31:0] rdy; logic [31:0] data;} ent_t;
  ent_t q[$];
  cordic_result_collector_if #(.DATA_W(32)) bus();
  cordic_result_collector #(.LATENCY(L), .DEPTH(D), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .inflight_cnt(inflight_cnt), .fifo_cnt(fifo_cnt)
  );
  always #5 clk = ~clk;
  assign bus.pipe_result = cyc + ofs;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // queue entries: result value and the cycle from which it is visible at the FIFO head
  task automatic tick();
    int nf, ni;
    logic ev, er;
    ent_t e;
    nf = 0;
    ni = 0;
    @(negedge clk);
    foreach (q[i]) if (q[i].rdy <= cyc) nf++; else ni++;
    ev = q.size() > 0 && q[0].rdy <= cyc;
    er = !bus.flush && q.size() < D;
    chk("res_valid", bus.res_valid, ev);
    if (ev) chk("res_data", bus.res_data, q[0].data);
    chk("fifo_cnt", fifo_cnt, nf);
    chk("inflight_cnt", inflight_cnt, ni);
    chk("req_ready", bus.req_ready, er);
    if (rst_n && bus.req_valid && bus.req_ready && !bus.flush) acc_dut++;
    if (!rst_n || bus.flush) q.delete();
    else begin
      if (ev && bus.res_ready) void'(q.pop_front());
      if (bus.req_valid && er) begin
        e.rdy = cyc + L + 1;
        e.data = cyc + L + ofs;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1 cyc++;
  endtask
  initial begin
    bus.req_valid = 0;
    bus.flush = 0;
    bus.res_ready = 0;
    @(posedge clk);
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_inflight_cnt", inflight_cnt, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    tick();
    tick();
    rst_n = 1;
    tick();
    bus.res_ready = 1;
    ofs = 32'h12345678 - (cyc + L);
    bus.req_valid = 1;
    tick();
    bus.req_valid = 0;
    repeat (L) tick();
    chk("single_valid", bus.res_valid, 1);
    chk("single_data", bus.res_data, 32'h12345678);
    tick();
    chk("single_drained", fifo_cnt, 0);
    tick();
    bus.res_ready = 0;
    bus.req_valid = 1;
    acc_dut = 0;
    repeat (23) tick();
    chk("bp_accepts", acc_dut, 16);
    chk("bp_full", fifo_cnt, 16);
    chk("bp_ready_low", bus.req_ready, 0);
    bus.req_valid = 0;
    bus.res_ready = 1;
    tick();
    chk("bp_ready_after_pop", bus.req_ready, 1);
    repeat (19) tick();
    ofs = 32'h0 - cyc;
    bus.req_valid = 1;
    for (int i = 0; i < 100; i++) begin
      if (!bus.req_ready) stalls++;
      if (i == 50) chk("stream_inflight", inflight_cnt, L);
      tick();
    end
    chk("stream_stalls", stalls, 0);
    bus.req_valid = 0;
    repeat (10) tick();
    bus.req_valid = 1;
    repeat (3) tick();
    bus.req_valid = 0;
    tick();
    bus.flush = 1;
    #1 chk("flush_ready", bus.req_ready, 0);
    tick();
    bus.flush = 0;
    chk("flush_inflight", inflight_cnt, 0);
    repeat (11) tick();
    bus.res_ready = 0;
    bus.req_valid = 1;
    repeat (16) tick();
    bus.req_valid = 0;
    repeat (6) tick();
    chk("sim_fifo15", fifo_cnt, 15);
    chk("sim_push_pending", inflight_cnt, 1);
    bus.res_ready = 1;
    tick();
    bus.res_ready = 0;
    chk("sim_fifo_hold", fifo_cnt, 15);
    bus.res_ready = 1;
    repeat (20) tick();
    bus.req_valid = 1;
    repeat (12) tick();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    bus.req_valid = 0;
    chk("flush_all_fifo", fifo_cnt, 0);
    chk("flush_all_inflight", inflight_cnt, 0);
    tick();
    ofs = $urandom;
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = $urandom_range(0, 3) != 0;
      bus.res_ready = $urandom_range(0, 2) != 0;
      bus.flush = $urandom_range(0, 39) == 0;
      tick();
    end
    bus.flush = 1;
    tick();
    bus.flush = 0;
    bus.res_ready = 0;
    bus.req_valid = 1;
    repeat (5) tick();
    bus.req_valid = 0;
    repeat (L) tick();
    chk("pre_rst_fifo", fifo_cnt, 5);
    bus.req_valid = 1;
    tick();
    tick();
    chk("pre_rst_inflight", inflight_cnt, 2);
    #2 rst_n = 0;
    #1;
    chk("arst_res_valid", bus.res_valid, 0);
    chk("arst_res_data", bus.res_data, 0);
    chk("arst_fifo_cnt", fifo_cnt, 0);
    chk("arst_inflight_cnt", inflight_cnt, 0);
    chk("arst_req_ready", bus.req_ready, 1);
    q.delete();
    tick();
    tick();
    rst_n = 1;
    bus.res_ready = 1;
    repeat (3) tick();
    bus.req_valid = 0;
    repeat (12) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cordic_result_collector.md
CORDIC_RESULT_COLLECTOR -- requirements
Module: cordic_result_collector

Interface
REQ-001 SHALL have parameter LATENCY, default 7, meaning the cordic pipeline depth in clock edges from target sample to valid cos_x.
REQ-002 SHALL have parameter DEPTH, default 16 (power of 2, >= LATENCY+1), meaning the result FIFO entry count.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the result width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset: asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1, meaning the upstream presents a target to the pipeline this cycle.
REQ-007 SHALL have port req_ready, output, 1, meaning a credit is available and the target may enter the pipeline.
REQ-008 SHALL have port flush, input, 1, meaning a synchronous discard of all in-flight and buffered results.
REQ-009 SHALL have port pipe_result, input, DATA_W, meaning the cos_x output of the cordic pipeline.
REQ-010 SHALL have port res_valid, output, 1, meaning the FIFO head is valid.
REQ-011 SHALL have port res_ready, input, 1, meaning the consumer accepts the head.
REQ-012 SHALL have port res_data, output, DATA_W, meaning the FIFO head data.
REQ-013 SHALL have port inflight_cnt, output, clog2(LATENCY+1), meaning the number of accepted requests not yet captured.
REQ-014 SHALL have port fifo_cnt, output, clog2(DEPTH+1), meaning the FIFO occupancy.

Function
REQ-015 SHALL define accept = req_valid & req_ready & ~flush, with req_ready = ~flush & ((inflight_cnt + fifo_cnt) < DEPTH), computed from registered counts only (no same-cycle pop look-ahead).
REQ-016 SHALL keep a LATENCY-bit valid shift register: vld[0] <= accept, vld[k] <= vld[k-1].
REQ-017 SHALL define push = vld[LATENCY-1] & ~flush, and SHALL write pipe_result into the FIFO tail on that edge; a request accepted in cycle T is captured at the end of cycle T+LATENCY.
REQ-018 SHALL define pop = res_valid & res_ready & ~flush, and SHALL advance the head pointer on that edge.
REQ-019 SHALL update inflight_cnt by +1 on accept and -1 on push; simultaneous accept and push leave it unchanged.
REQ-020 SHALL update fifo_cnt by +1 on push and -1 on pop; simultaneous push and pop leave it unchanged, including when fifo_cnt = DEPTH-1 or 1.
REQ-021 SHALL wrap read and write pointers modulo DEPTH.
REQ-022 SHALL drive res_valid = (fifo_cnt != 0) and res_data = mem[rd_ptr], with no empty-FIFO bypass; request-to-res_valid latency is LATENCY+1 cycles.
REQ-023 SHALL never push while full; this is guaranteed by the credit rule in REQ-015, and a push into a full FIFO SHALL be flagged as an assertion failure.
REQ-024 SHALL, on flush, on the next edge: clear vld, inflight_cnt, fifo_cnt and both pointers.
REQ-025 SHALL give flush priority over accept, push and pop in the same cycle.
REQ-026 SHALL never present pipe_result values from flushed requests at res_data.
REQ-027 SHALL preserve FIFO order: results leave in request-acceptance order.
REQ-028 SHALL hold res_data stable while res_valid = 1 and res_ready = 0.

Reset
REQ-029 SHALL, while rst_n = 0, asynchronously clear vld, pointers, inflight_cnt, fifo_cnt and all FIFO entries.
REQ-030 SHALL, during and after reset, drive res_valid = 0, res_data = 0, inflight_cnt = 0, fifo_cnt = 0 and req_ready = 1 (when flush = 0).
REQ-031 SHALL, when reset asserts mid-operation, discard all in-flight and buffered results.
REQ-032 SHALL, after rst_n deasserts, perform its first capture only for requests accepted after release.

Verification
REQ-033 SHALL cover reset: rst_n = 0 asynchronously mid-stream with fifo_cnt = 5 -> immediately res_valid = 0, res_data = 0x00000000, fifo_cnt = 0, inflight_cnt = 0, req_ready = 1.
REQ-034 SHALL cover a single request: req_valid = 1 in cycle 0, pipe_result = 0x12345678 in cycle 7, res_ready = 1 -> res_valid = 1 only in cycle 8 with res_data = 0x12345678; fifo_cnt returns to 0 in cycle 9.
REQ-035 SHALL cover backpressure: res_ready = 0, req_valid held high -> exactly 16 accepts (cycles 0-15), req_ready = 0 from cycle 16, fifo_cnt = 16 by cycle 23; then res_ready = 1 -> 16 results pop in order and req_ready = 1 one cycle after the first pop.
REQ-036 SHALL cover streaming: res_ready = 1, req_valid = 1 for 100 cycles with pipe_result = cycle number -> 100 accepts with no stall, res_data sequence 7..106 in cycles 8..107, inflight_cnt steady at 7.
REQ-037 SHALL cover a mid-flight flush: 3 accepts in cycles 0-2, flush = 1 in cycle 4 -> req_ready = 0 in cycle 4, inflight_cnt = 0 in cycle 5, and res_valid = 0 through cycle 15.
REQ-038 SHALL cover simultaneous events: fifo_cnt = 15, push and pop in the same cycle -> fifo_cnt stays 15; flush coincident with push and pop -> fifo_cnt = 0.
